// File: rtl/puf_crp_ctrl.sv
// Arbiter-PUF challenge/response controller: LFSR challenge generation, latch
// clear/launch/sample sequencing and response collection. Optional PUF_MAJORITY_EN.
module puf_crp_ctrl #(
  parameter int unsigned N         = 128,
  parameter int unsigned RESP_BITS = 32,
  parameter int unsigned SETTLE    = 8,
  parameter logic [N-1:0] TAPS     = 128'hA000_0014_0000_0000_0000_0000_0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N-1:0]         seed,
  output logic                 busy,
  output logic [N-1:0]         challenge,
  output logic                 launch,
  output logic                 latch_rst,
  input  logic                 puf_out,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready
);

  localparam int unsigned KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [N-1:0]           challenge_q, challenge_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic [KW-1:0]          k_q, k_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   sync1_q, sync2_q;
  logic                   puf_s;
  logic                   resp_bit;

`ifdef PUF_MAJORITY_EN
  logic [1:0]             rep_q, rep_d;
  logic [2:0]             votes_q, votes_d;
  assign resp_bit = (votes_q[0] & votes_q[1]) | (votes_q[0] & votes_q[2]) |
                    (votes_q[1] & votes_q[2]);
`else
  logic                   sample_q, sample_d;
  assign resp_bit = sample_q;
`endif

  assign puf_s = sync2_q;

  // puf_out is asynchronous to clk; never used before the second flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= puf_out;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      challenge_q <= '0;
      resp_q      <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
`ifdef PUF_MAJORITY_EN
      rep_q       <= '0;
      votes_q     <= '0;
`else
      sample_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      challenge_q <= challenge_d;
      resp_q      <= resp_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
`ifdef PUF_MAJORITY_EN
      rep_q       <= rep_d;
      votes_q     <= votes_d;
`else
      sample_q    <= sample_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    challenge_d = challenge_q;
    resp_d      = resp_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
`ifdef PUF_MAJORITY_EN
    rep_d       = rep_q;
    votes_d     = votes_q;
`else
    sample_d    = sample_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          challenge_d = (seed == '0) ? '1 : seed;
          resp_d      = '0;
          k_d         = '0;
          cnt_d       = '0;
`ifdef PUF_MAJORITY_EN
          rep_d       = '0;
`endif
          state_d     = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        if (cnt_q == 8'd1) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_WAIT: begin
        if (cnt_q == 8'(SETTLE - 1)) begin
          cnt_d = '0;
`ifdef PUF_MAJORITY_EN
          votes_d[rep_q] = puf_s;
          if (rep_q == 2'd2) begin
            rep_d   = '0;
            state_d = ST_NEXT;
          end else begin
            rep_d   = rep_q + 2'd1;
            state_d = ST_CLEAR;
          end
`else
          sample_d = puf_s;
          state_d  = ST_NEXT;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_NEXT: begin
        resp_d[k_q] = resp_bit;
        challenge_d = {challenge_q[N-2:0], ^(challenge_q & TAPS)};
        k_d         = k_q + 1'b1;
        state_d     = (k_q == KW'(RESP_BITS - 1)) ? ST_DONE : ST_CLEAR;
      end

      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign challenge  = challenge_q;
  assign launch     = (state_q == ST_WAIT);
  assign latch_rst  = (state_q == ST_IDLE) || (state_q == ST_CLEAR) || (state_q == ST_DONE);
  assign resp       = resp_q;
  assign resp_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_puf_crp_ctrl.sv
// Scoreboard bench for puf_crp_ctrl; expected responses queued by stimulus,
// popped and checked by a monitor when resp_valid rises.
module tb_puf_crp_ctrl;

  localparam int N  = 128;
  localparam int RB = 32;
`ifdef PUF_MAJORITY_EN
  localparam int  PER = 31;
  localparam int  LAT = 992;
  localparam bit  MAJ = 1'b1;
`else
  localparam int  PER = 11;
  localparam int  LAT = 352;
  localparam bit  MAJ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  seed;
  logic          busy;
  logic [N-1:0]  challenge;
  logic          launch;
  logic          latch_rst;
  logic          puf_out;
  logic [RB-1:0] resp;
  logic          resp_valid;
  logic          resp_ready;

  typedef struct {
    logic [RB-1:0] resp;
    time           t0;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic vprev  = 1'b0;

  puf_crp_ctrl #(.N(N), .RESP_BITS(RB), .SETTLE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seed       (seed),
    .busy       (busy),
    .challenge  (challenge),
    .launch     (launch),
    .latch_rst  (latch_rst),
    .puf_out    (puf_out),
    .resp       (resp),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per resp_valid rising edge
  always @(negedge clk) begin
    if (resp_valid && !vprev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_resp_valid", 128'(resp_valid), 128'd0);
      end else begin
        exp_t it;
        it = sb_q.pop_front();
        check("resp", 128'(resp), 128'(it.resp));
        check("latency", 128'(($time - it.t0 - 5) / 10), 128'(LAT));
      end
    end
    vprev = resp_valid;
  end

  // mode: 0 no challenge checks, 1 seed=1 sequence, 2 seed=0 sequence
  task automatic run(input logic [N-1:0] sd, input logic [RB-1:0] pat, input int mode);
    exp_t          it;
    logic [N-1:0]  one;
    logic [N-1:0]  expc;
    int            b, o, e, n;
    one = 1;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(posedge clk);
    it.resp = pat;
    it.t0   = $time;
    sb_q.push_back(it);
    #1 start = 1'b0;
    for (int c = 0; c < RB * PER; c++) begin
      b = c / PER;
      o = c % PER;
      e = o / 10;
      if (MAJ) puf_out = (e == 1) ? ~pat[b] : pat[b];
      else     puf_out = pat[b];
      if (b == 0 && o == 0) begin
        check("busy_run", 128'(busy), 128'd1);
        check("clear_outs", 128'({launch, latch_rst}), 128'(2'b01));
      end
      if (b == 0 && o == 2)
        check("wait_outs", 128'({launch, latch_rst}), 128'(2'b10));
      if (b == 0 && o == PER - 1)
        check("next_outs", 128'({launch, latch_rst}), 128'(2'b00));
      if ((o == 0 || o == PER - 2) &&
          ((mode == 1 && (b <= 2 || b == 31)) || (mode == 2 && b <= 1))) begin
        if (mode == 1)      expc = one << b;
        else if (b == 0)    expc = '1;
        else                expc = ~one;
        check($sformatf("challenge_b%0d_o%0d", b, o), challenge, expc);
      end
      @(posedge clk);
      #1;
    end
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!resp_valid) check("resp_valid_timeout", 128'(resp_valid), 128'd1);
    if (resp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    seed       = '0;
    puf_out    = 1'b0;
    resp_ready = 1'b1;
    #12;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_outs", 128'({launch, latch_rst, resp_valid}), 128'(3'b010));
    check("rst_challenge", challenge, 128'd0);
    check("rst_resp", 128'(resp), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run(128'h1, 32'hFFFF_FFFF, 1);
    run(128'h0, 32'hA5A5_0F0F, 2);
    run(128'h1234_5678_9ABC_DEF0, 32'h8000_0001, 0);
    run(128'h5, 32'h0000_0000, 0);

    // Consumer stalls 20 cycles; start pulses while in DONE must be ignored
    resp_ready = 1'b0;
    run(128'h3, 32'h1234_5678, 0);
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      check($sformatf("hold_valid_%0d", i), 128'(resp_valid), 128'd1);
      check($sformatf("hold_resp_%0d", i), 128'(resp), 128'h1234_5678);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("handshake_idle", 128'({busy, resp_valid}), 128'd0);
    @(posedge clk);
    #1;
    check("start_ignored_in_done", 128'(busy), 128'd0);

    // Mid-run asynchronous reset
    @(negedge clk);
    seed  = 128'h1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    puf_out = 1'b1;
    repeat (99) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_outs", 128'({launch, latch_rst, resp_valid}), 128'(3'b010));
    check("abort_challenge", challenge, 128'd0);
    check("abort_resp", 128'(resp), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    check("abort_stays_idle", 128'({busy, resp_valid}), 128'd0);

    run(128'h1, 32'h0F0F_A5A5, 1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_crp_ctrl.md
PUF_CRP_CTRL -- requirements
Module: puf_crp_ctrl

Interface
REQ-001 SHALL have parameter N, default 128: challenge width, equal to the arbiter chain length.
REQ-002 SHALL have parameter RESP_BITS, default 32: response bits collected per run.
REQ-003 SHALL have parameter SETTLE, default 8: launch-to-sample cycles, legal range 3..255.
REQ-004 SHALL have parameter TAPS, default 128'hA000_0014_0000_0000_0000_0000_0000_0000: LFSR feedback mask, N bits (taps at bits 127, 125, 100, 98).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-008 SHALL have port seed, input, N bits: LFSR seed, loaded when start is accepted.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port challenge, output, N bits: drives the arbiter chain select bus.
REQ-011 SHALL have port launch, output, 1 bit: drives the arbiter chain input edge.
REQ-012 SHALL have port latch_rst, output, 1 bit: drives the arbiter latch reset.
REQ-013 SHALL have port puf_out, input, 1 bit: arbiter latch output, asynchronous to clk.
REQ-014 SHALL have port resp, output, RESP_BITS bits: collected response.
REQ-015 SHALL have port resp_valid, output, 1 bit: resp is complete.
REQ-016 SHALL have port resp_ready, input, 1 bit: consumer accepts resp.

Function
REQ-017 SHALL pass puf_out through a 2-flop synchronizer (puf_s) before any use.
REQ-018 SHALL implement FSM states IDLE, CLEAR, WAIT, NEXT, DONE.
REQ-019 IDLE: start=1 SHALL load challenge with seed (all-ones if seed==0), clear resp and the bit counter, and enter CLEAR next cycle.
REQ-020 CLEAR SHALL last exactly 2 cycles with latch_rst=1 and launch=0, then enter WAIT.
REQ-021 WAIT SHALL last exactly SETTLE cycles with latch_rst=0 and launch=1; on its final cycle puf_s SHALL be sampled.
REQ-022 NEXT SHALL last 1 cycle with launch=0 and latch_rst=0.
REQ-023 NEXT SHALL write the sample to resp[k], where k = bit counter, 0 = first challenge.
REQ-024 NEXT SHALL advance the LFSR: challenge <= {challenge[N-2:0], ^(challenge & TAPS)}.
REQ-025 NEXT SHALL increment k, then enter DONE if k==RESP_BITS-1, else CLEAR.
REQ-026 challenge SHALL remain stable from entry into CLEAR through the end of WAIT.
REQ-027 DONE SHALL hold resp_valid=1 and resp stable until a cycle with resp_ready=1, then return to IDLE with resp_valid=0.
REQ-028 start SHALL be ignored outside IDLE; simultaneous resp_ready and start in DONE SHALL complete the handshake only, and start is not accepted that cycle.
REQ-029 Latency from the start-accept edge to resp_valid SHALL be exactly RESP_BITS*(SETTLE+3) cycles (352 at defaults).

Reset
REQ-030 rst_n low SHALL asynchronously force: state=IDLE, challenge=0, launch=0, latch_rst=1, resp=0, resp_valid=0, busy=0, k=0, synchronizer flops=0.
REQ-031 latch_rst SHALL be 1 in IDLE and DONE, and 0 in WAIT and NEXT.
REQ-032 Reset asserted mid-run SHALL abort the run without producing resp_valid; after release the block waits in IDLE for a new start.

Configuration
REQ-033 Macro PUF_MAJORITY_EN defined: each challenge SHALL be evaluated 3 times (CLEAR+WAIT ×3) before a single NEXT.
REQ-034 With PUF_MAJORITY_EN, the value written to resp[k] SHALL be the majority of the 3 samples.
REQ-035 With PUF_MAJORITY_EN, latency SHALL be RESP_BITS*(3*(SETTLE+2)+1) cycles (992 at defaults).
REQ-036 Macro PUF_MAJORITY_EN undefined: single evaluation per REQ-020..REQ-029; no vote logic is present.

Verification
REQ-037 puf_out tied 1, seed=128'h1, start pulse -> resp_valid exactly 352 cycles later, resp=32'hFFFF_FFFF.
REQ-038 seed=128'h1 -> challenge sequence 128'h1, 128'h2, 128'h4, …; seed=0 -> first challenge all-ones.
REQ-039 puf_out = bit k of 32'hA5A5_0F0F applied during evaluation k -> resp=32'hA5A5_0F0F.
REQ-040 resp_ready held 0 for 20 cycles after resp_valid -> resp and resp_valid hold for all 20 cycles; start pulses during this window are ignored; IDLE reached one cycle after resp_ready=1.
REQ-041 rst_n pulsed low at cycle 100 of a run -> all outputs at reset values immediately; no resp_valid until a new start.
REQ-042 PUF_MAJORITY_EN defined, puf_out samples 1,0,1 per challenge -> resp=32'hFFFF_FFFF at cycle 992.
